// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port, registered-read SRAM between an
// instruction-fetch read port and a data read/write port, with a one-deep response buffer per port.
module sram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              i_rready,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              d_rready,

    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    // Handshake: a request completes on req & ready; a response is held
    // (rvalid/rdata stable) until the cycle where rvalid & rready, and clears at that edge.

    logic i_inflight;
    logic d_inflight;
    logic last_grant_d;
    logic inst_elig;
    logic data_elig;
    logic grant_i;
    logic grant_d;

    // A port with an outstanding read cannot start another; writes need no response slot.
    always_comb begin
        inst_elig = i_req & ~i_inflight & ~i_rvalid;
        data_elig = d_req & (d_we | (~d_inflight & ~d_rvalid));
        grant_i   = ~rst & inst_elig & (~data_elig | last_grant_d);
        grant_d   = ~rst & data_elig & (~inst_elig | ~last_grant_d);
    end

    always_comb begin
        i_ready    = grant_i;
        d_ready    = grant_d;
        sram_we    = grant_d & d_we;
        sram_en    = grant_i | (grant_d & ~d_we);
        sram_addr  = grant_i ? i_addr : d_addr;
        sram_wdata = d_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if (grant_i | grant_d) begin
            last_grant_d <= grant_d;
        end
    end

    // Instruction port: IDLE -> INFLIGHT -> HOLD -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_inflight <= 1'b0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
        end else begin
            i_inflight <= grant_i;
            if (i_inflight) begin
                i_rvalid <= 1'b1;
                i_rdata  <= sram_rdata;
            end else if (i_rvalid & i_rready) begin
                i_rvalid <= 1'b0;
            end
        end
    end

    // Data port: only reads pass through INFLIGHT/HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_inflight <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
        end else begin
            d_inflight <= grant_d & ~d_we;
            if (d_inflight) begin
                d_rvalid <= 1'b1;
                d_rdata  <= sram_rdata;
            end else if (d_rvalid & d_rready) begin
                d_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized and directed bench for sram_arbiter: a transaction-level reference
// model predicts grants and read data, a separate monitor checks the responses.
module tb_sram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_ready, i_rvalid, i_rready;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_ready, d_rvalid, d_rready;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_rready(i_rready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rready(d_rready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // ---------------- clock / reset / SRAM ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_en) sram_rdata <= mem[sram_addr];
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0] i_exp_q[$];
    int            i_cyc_q[$];
    logic [DW-1:0] d_exp_q[$];
    int            d_cyc_q[$];

    bit m_i_busy, m_d_busy, m_last_d;
    int m_i_acc, m_d_acc;

    always @(negedge clk) begin
        bit i_el, d_el, gi, gd;
        if (rst) begin
            m_i_busy = 0;
            m_d_busy = 0;
            m_last_d = 0;
            i_exp_q.delete(); i_cyc_q.delete();
            d_exp_q.delete(); d_cyc_q.delete();
            check("rst_i_ready", i_ready, 0);
            check("rst_d_ready", d_ready, 0);
            check("rst_sram_en", sram_en, 0);
            check("rst_sram_we", sram_we, 0);
            check("rst_i_rvalid", i_rvalid, 0);
            check("rst_d_rvalid", d_rvalid, 0);
        end else begin
            i_el = i_req && !m_i_busy;
            d_el = d_req && (d_we || !m_d_busy);
            gi   = i_el && (!d_el || m_last_d);
            gd   = d_el && (!i_el || !m_last_d);
            check("i_ready", i_ready, gi);
            check("d_ready", d_ready, gd);
            check("sram_en", sram_en, gi || (gd && !d_we));
            check("sram_we", sram_we, gd && d_we);
            if (gi) check("sram_addr_i", sram_addr, i_addr);
            if (gd) check("sram_addr_d", sram_addr, d_addr);
            if (gd && d_we) check("sram_wdata", sram_wdata, d_wdata);
            // a response is visible from two cycles after acceptance until consumed
            if (m_i_busy && cyc >= m_i_acc + 2 && i_rready) m_i_busy = 0;
            if (m_d_busy && cyc >= m_d_acc + 2 && d_rready) m_d_busy = 0;
            if (gi) begin
                m_i_busy = 1;
                m_i_acc  = cyc;
                i_exp_q.push_back(ref_mem[i_addr]);
                i_cyc_q.push_back(cyc + 2);
            end
            if (gd && d_we) ref_mem[d_addr] = d_wdata;
            if (gd && !d_we) begin
                m_d_busy = 1;
                m_d_acc  = cyc;
                d_exp_q.push_back(ref_mem[d_addr]);
                d_cyc_q.push_back(cyc + 2);
            end
            if (gi || gd) m_last_d = gd;
        end
    end

    // ---------------- response monitor ----------------
    bit            i_held, d_held;
    logic [DW-1:0] i_hold_data, d_hold_data;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            i_held = 0;
            d_held = 0;
        end else begin
            if (i_held) begin
                if (!i_rvalid) begin
                    check("i_rvalid_dropped", i_rvalid, 1);
                    i_held = 0;
                end else begin
                    check("i_rdata_stable", i_rdata, i_hold_data);
                end
            end else if (i_rvalid) begin
                if (i_exp_q.size() == 0) begin
                    check("i_spurious_rvalid", i_rvalid, 0);
                end else begin
                    check("i_rdata", i_rdata, i_exp_q.pop_front());
                    check("i_latency", cyc, i_cyc_q.pop_front());
                end
                i_held = 1;
                i_hold_data = i_rdata;
            end else if (i_cyc_q.size() > 0 && cyc > i_cyc_q[0]) begin
                check("i_late", i_rvalid, 1);
                void'(i_exp_q.pop_front());
                void'(i_cyc_q.pop_front());
            end
            if (i_rvalid && i_rready) i_held = 0;

            if (d_held) begin
                if (!d_rvalid) begin
                    check("d_rvalid_dropped", d_rvalid, 1);
                    d_held = 0;
                end else begin
                    check("d_rdata_stable", d_rdata, d_hold_data);
                end
            end else if (d_rvalid) begin
                if (d_exp_q.size() == 0) begin
                    check("d_spurious_rvalid", d_rvalid, 0);
                end else begin
                    check("d_rdata", d_rdata, d_exp_q.pop_front());
                    check("d_latency", cyc, d_cyc_q.pop_front());
                end
                d_held = 1;
                d_hold_data = d_rdata;
            end else if (d_cyc_q.size() > 0 && cyc > d_cyc_q[0]) begin
                check("d_late", d_rvalid, 1);
                void'(d_exp_q.pop_front());
                void'(d_cyc_q.pop_front());
            end
            if (d_rvalid && d_rready) d_held = 0;
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_i_read(input logic [AW-1:0] a);
        bit acc = 0;
        int n = 0;
        i_req  = 1'b1;
        i_addr = a;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = i_ready;
            n++;
            step();
        end
        i_req = 1'b0;
        if (!acc) check("i_accept_timeout", i_ready, 1);
    endtask

    task automatic do_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bit acc = 0;
        int n = 0;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = d_ready;
            n++;
            step();
        end
        d_req = 1'b0;
        if (!acc) check("d_accept_timeout", d_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < (1 << AW); k++) begin
            logic [DW-1:0] v;
            v = $urandom;
            mem[k]     = v;
            ref_mem[k] = v;
        end
        mem[12'h010]     = 32'hDEAD_BEEF;
        ref_mem[12'h010] = 32'hDEAD_BEEF;

        rst = 1'b1;
        i_req = 0; i_addr = '0; i_rready = 1'b1;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_rready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_i_rdata", i_rdata, 0);
        check("reset_d_rdata", d_rdata, 0);
        step();

        // single instruction read
        do_i_read(12'h010);
        repeat (4) step();

        // write followed immediately by a read of the same word
        do_d(1'b1, 12'h0A5, 32'h1234_5678);
        do_d(1'b0, 12'h0A5, '0);
        repeat (4) step();

        // contention: both ports reading continuously
        i_req = 1; d_req = 1; d_we = 0;
        for (int k = 0; k < 14; k++) begin
            i_addr = 12'($urandom_range(0, 63));
            d_addr = 12'($urandom_range(0, 63));
            step();
        end
        i_req = 0; d_req = 0;
        repeat (4) step();

        // instruction backpressure while the data port keeps working
        i_rready = 0;
        do_i_read(12'h001);
        i_req = 1; i_addr = 12'h002;
        for (int k = 0; k < 6; k++) begin
            d_req   = 1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 12'($urandom_range(0, 63));
            d_wdata = $urandom;
            step();
        end
        d_req = 0;
        i_rready = 1;
        repeat (2) step();
        i_req = 0;
        repeat (4) step();

        // writes back to back while an instruction response is held
        i_rready = 0;
        do_i_read(12'h020);
        repeat (2) step();
        d_req = 1; d_we = 1;
        for (int k = 0; k < 4; k++) begin
            d_addr  = 12'h100 + 12'(k);
            d_wdata = $urandom;
            step();
        end
        d_req = 0;
        i_rready = 1;
        step();
        for (int k = 0; k < 4; k++) do_d(1'b0, 12'h100 + 12'(k), '0);
        repeat (4) step();

        // asynchronous reset while a response is held
        i_rready = 0;
        do_i_read(12'h030);
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("async_rst_i_rvalid", i_rvalid, 0);
        check("async_rst_i_rdata", i_rdata, 0);
        step();
        rst = 1'b0;
        i_rready = 1;
        repeat (2) step();

        // reset in the cycle after a read is accepted: no response may follow
        do_i_read(12'h040);
        rst = 1'b1;
        #1;
        check("midread_rst_i_rvalid", i_rvalid, 0);
        step();
        rst = 1'b0;
        repeat (6) step();

        // random traffic on a small address window to force collisions
        for (int k = 0; k < 1500; k++) begin
            i_req    = ($urandom_range(0, 3) != 0);
            i_addr   = 12'($urandom_range(0, 31));
            d_req    = ($urandom_range(0, 3) != 0);
            d_we     = 1'($urandom_range(0, 1));
            d_addr   = 12'($urandom_range(0, 31));
            d_wdata  = $urandom;
            i_rready = ($urandom_range(0, 3) != 0);
            d_rready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; i_req = 0; d_req = 0; i_rready = 1; d_rready = 1;
        repeat (10) step();
        check("i_queue_drained", i_exp_q.size(), 0);
        check("d_queue_drained", d_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
